// File: rtl/pipe_stage_skid_reg_pkg.sv
// Shared constants for the MIPS pipeline stage registers: FSM encoding,
// control-bundle bit positions and per-stage datapath widths.
package pipe_pkg;

  // Encoding is {skid_v, main_v}; 2'b10 never occurs in normal operation.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_BUSY  = 2'b01,
    ST_FULL  = 2'b11
  } state_t;

  localparam int CTRL_W_DEF = 8;

  localparam int CB_WE_REG       = 0;
  localparam int CB_JAL_SEL      = 1;
  localparam int CB_JUMP         = 2;
  localparam int CB_DM2REG       = 3;
  localparam int CB_SUPER_SEL_LO = 4;
  localparam int CB_SUPER_SEL_HI = 5;
  localparam int CB_JR_SEL       = 6;
  localparam int CB_MULTU_EN     = 7;

  localparam int IFID_W     = 2 * 32;
  localparam int IDEX_W     = 7 * 32 + 5;
  localparam int EXMEM_W    = 6 * 32 + 64 + 5;
  localparam int MEMWB_W    = 7 * 32 + 64 + 5;
  localparam int DATA_W_DEF = MEMWB_W;

endpackage

// File: rtl/pipe_stage_skid_reg_if.sv
// Valid/ready channel carrying one pipeline entry (control + datapath bundle).
interface pipe_stage_skid_reg_if #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 293
);
  // A transfer happens on a rising edge where valid & ready are both 1.
  // The master holds ctrl/data stable while valid & !ready; ready may be
  // asserted with or without valid and never depends on a future cycle.
  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (output valid, output ctrl, output data, input ready);
  modport slave  (input valid, input ctrl, input data, output ready);
endinterface

// File: rtl/pipe_stage_skid_reg_slot.sv
// One storage slot of a stage register: valid flag plus control and datapath
// bundles. Clear drops only the valid flag; data keeps its last value.
module stage_slot #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 293
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_data  <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_ctrl  <= i_ctrl;
      r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_ctrl  = r_ctrl;
  assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Pipeline stage register with stall, flush, optional one-entry skid buffer
// (registered in_ready) and a saturating stall counter.
module pipe_stage_skid_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W  = CTRL_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter bit SKID_EN = 1'b1,
  parameter int CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  pipe_stage_skid_reg_if.slave   s_in,
  pipe_stage_skid_reg_if.master  m_out,
  output logic [CNT_W-1:0]       stall_cnt,
  output state_t                 o_state
);

  logic              w_main_v, w_skid_v;
  logic [CTRL_W-1:0] w_main_ctrl, w_skid_ctrl, w_main_ctrl_d;
  logic [DATA_W-1:0] w_main_data, w_skid_data, w_main_data_d;
  logic              w_in_ready, w_accept, w_drain;
  logic              w_main_load, w_main_clear, w_main_from_skid;
  logic              w_skid_load, w_skid_clear;
  state_t            w_state;
  logic [CNT_W-1:0]  r_stall_cnt;

  // The state register is the pair of slot valid flags.
  assign w_state  = state_t'({w_skid_v, w_main_v});
  assign w_accept = s_in.valid & w_in_ready;
  assign w_drain  = w_main_v & m_out.ready;

  always_comb begin
    w_main_load      = 1'b0;
    w_main_clear     = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_load      = 1'b0;
    w_skid_clear     = 1'b0;
    if (flush) begin
      w_main_clear = 1'b1;
      w_skid_clear = 1'b1;
    end else begin
      case (w_state)
        ST_EMPTY: w_main_load = w_accept;
        ST_BUSY: begin
          if (w_accept && w_drain) w_main_load  = 1'b1;
          else if (w_accept)       w_skid_load  = 1'b1;
          else if (w_drain)        w_main_clear = 1'b1;
        end
        ST_FULL: begin
          if (w_drain) begin
            w_main_load      = 1'b1;
            w_main_from_skid = 1'b1;
            w_skid_clear     = 1'b1;
          end
        end
        default: begin
          w_main_clear = 1'b1;
          w_skid_clear = 1'b1;
        end
      endcase
    end
  end

  assign w_main_ctrl_d = w_main_from_skid ? w_skid_ctrl : s_in.ctrl;
  assign w_main_data_d = w_main_from_skid ? w_skid_data : s_in.data;

  stage_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_main_load),
    .i_clear (w_main_clear),
    .i_ctrl  (w_main_ctrl_d),
    .i_data  (w_main_data_d),
    .o_valid (w_main_v),
    .o_ctrl  (w_main_ctrl),
    .o_data  (w_main_data)
  );

  generate
    if (SKID_EN) begin : g_skid
      stage_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_ctrl  (s_in.ctrl),
        .i_data  (s_in.data),
        .o_valid (w_skid_v),
        .o_ctrl  (w_skid_ctrl),
        .o_data  (w_skid_data)
      );
      // Comes straight from a flop, so upstream sees no combinational path.
      assign w_in_ready = ~w_skid_v;
    end else begin : g_no_skid
      assign w_skid_v    = 1'b0;
      assign w_skid_ctrl = '0;
      assign w_skid_data = '0;
      assign w_in_ready  = m_out.ready | ~w_main_v;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_main_v && !m_out.ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Bubbles carry all-zero control so they never write RF, HI/LO or DM.
  assign m_out.valid = w_main_v;
  assign m_out.ctrl  = w_main_v ? w_main_ctrl : '0;
  assign m_out.data  = w_main_data;
  assign s_in.ready  = w_in_ready;
  assign stall_cnt   = r_stall_cnt;
  assign o_state     = w_state;

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Bench for pipe_stage_skid_reg: three instances (skid/16-bit count,
// skid/4-bit count, no skid) share one stimulus and a queue-based model.
module tb_pipe_stage_skid_reg;
  import pipe_pkg::*;

  localparam int CW = CTRL_W_DEF;
  localparam int DW = MEMWB_W;
  localparam int EW = CW + DW;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;

  pipe_stage_skid_reg_if #(.CTRL_W(CW), .DATA_W(DW)) in_a ();
  pipe_stage_skid_reg_if #(.CTRL_W(CW), .DATA_W(DW)) out_a ();
  pipe_stage_skid_reg_if #(.CTRL_W(CW), .DATA_W(DW)) in_b ();
  pipe_stage_skid_reg_if #(.CTRL_W(CW), .DATA_W(DW)) out_b ();
  pipe_stage_skid_reg_if #(.CTRL_W(CW), .DATA_W(DW)) in_c ();
  pipe_stage_skid_reg_if #(.CTRL_W(CW), .DATA_W(DW)) out_c ();

  assign in_a.valid = in_valid;  assign in_a.ctrl = in_ctrl;  assign in_a.data = in_data;
  assign in_b.valid = in_valid;  assign in_b.ctrl = in_ctrl;  assign in_b.data = in_data;
  assign in_c.valid = in_valid;  assign in_c.ctrl = in_ctrl;  assign in_c.data = in_data;
  assign out_a.ready = out_ready;
  assign out_b.ready = out_ready;
  assign out_c.ready = out_ready;

  logic [15:0] stall_a, stall_c;
  logic [3:0]  stall_b;
  state_t      st_a, st_b, st_c;

  pipe_stage_skid_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID_EN(1'b1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .s_in(in_a), .m_out(out_a),
    .stall_cnt(stall_a), .o_state(st_a));
  pipe_stage_skid_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID_EN(1'b1), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .s_in(in_b), .m_out(out_b),
    .stall_cnt(stall_b), .o_state(st_b));
  pipe_stage_skid_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID_EN(1'b0), .CNT_W(16)) dut_c (
    .clk(clk), .rst(rst), .flush(flush), .s_in(in_c), .m_out(out_c),
    .stall_cnt(stall_c), .o_state(st_c));

  // scoreboard: expected contents of each stage, oldest first
  logic [EW-1:0] exp_qa[$];  // two-entry stages (dut_a and dut_b)
  logic [EW-1:0] exp_qc[$];  // one-entry stage (dut_c)
  int cnt_a = 0, cnt_b = 0, cnt_c = 0;
  int n_checks = 0, n_errors = 0;

  // A stage is a FIFO of capacity 2 (skid) or 1; ready rules are evaluated
  // on the state before the edge.
  task automatic model_edge();
    bit acc, drn;
    if (rst) begin
      exp_qa.delete(); exp_qc.delete();
      cnt_a = 0; cnt_b = 0; cnt_c = 0;
    end else begin
      if (exp_qa.size() != 0 && !out_ready) begin
        if (cnt_a < 65535) cnt_a++;
        if (cnt_b < 15) cnt_b++;
      end
      drn = (exp_qa.size() != 0) && out_ready;
      acc = in_valid && (exp_qa.size() < 2);
      if (flush) exp_qa.delete();
      else begin
        if (drn) void'(exp_qa.pop_front());
        if (acc) exp_qa.push_back({in_ctrl, in_data});
      end
      if (exp_qc.size() != 0 && !out_ready && cnt_c < 65535) cnt_c++;
      drn = (exp_qc.size() != 0) && out_ready;
      acc = in_valid && (out_ready || exp_qc.size() == 0);
      if (flush) exp_qc.delete();
      else begin
        if (drn) void'(exp_qc.pop_front());
        if (acc) exp_qc.push_back({in_ctrl, in_data});
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    d = '0;
    for (int i = 0; i < 10; i++) d = {d[DW-33:0], 32'($urandom())};
    return d;
  endfunction

  // driver / scenario tasks
  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    in_ctrl = 8'hFF; in_data = rand_data();
    tick(); tick();
    n_checks++; if (out_a.valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got %0h exp 0", out_a.valid); end
    n_checks++; if (out_a.ctrl !== 8'h00) begin n_errors++; $display("FAIL reset_ctrl got %0h exp 0", out_a.ctrl); end
    n_checks++; if (out_a.data !== '0) begin n_errors++; $display("FAIL reset_data got %0h exp 0", out_a.data); end
    n_checks++; if (stall_a !== 16'd0) begin n_errors++; $display("FAIL reset_stall got %0d exp 0", stall_a); end
    n_checks++; if (in_a.ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready got %0h exp 1", in_a.ready); end
    n_checks++; if (st_a !== ST_EMPTY) begin n_errors++; $display("FAIL reset_state got %0h exp 0", st_a); end
    n_checks++; if (in_c.ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready_noskid got %0h exp 1", in_c.ready); end
    rst = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_streaming();
    out_ready = 1'b1; in_ctrl = 8'hA5;
    for (int i = 1; i <= 10; i++) begin
      in_valid = 1'b1; in_data = DW'(i);
      tick();
      n_checks++; if (out_a.valid !== 1'b1 || out_a.data !== DW'(i)) begin n_errors++; $display("FAIL stream_data got %0h/%0h exp 1/%0h", out_a.valid, out_a.data, i); end
      n_checks++; if (out_a.ctrl !== 8'hA5) begin n_errors++; $display("FAIL stream_ctrl got %0h exp a5", out_a.ctrl); end
      n_checks++; if (out_c.valid !== 1'b1 || out_c.data !== DW'(i)) begin n_errors++; $display("FAIL stream_data_noskid got %0h/%0h exp 1/%0h", out_c.valid, out_c.data, i); end
    end
    in_valid = 1'b0;
    tick();
    n_checks++; if (out_a.valid !== 1'b0 || out_a.ctrl !== 8'h00) begin n_errors++; $display("FAIL stream_end got %0h/%0h exp 0/0", out_a.valid, out_a.ctrl); end
    n_checks++; if (stall_a !== 16'd0) begin n_errors++; $display("FAIL stream_stall got %0d exp 0", stall_a); end
  endtask

  task automatic test_backpressure();
    in_valid = 1'b1; in_data = DW'(1); out_ready = 1'b1;
    tick();
    n_checks++; if (out_a.data !== DW'(1)) begin n_errors++; $display("FAIL bp_first got %0h exp 1", out_a.data); end
    out_ready = 1'b0; in_data = DW'(2);
    tick();
    n_checks++; if (in_a.ready !== 1'b0) begin n_errors++; $display("FAIL bp_ready_drop got %0h exp 0", in_a.ready); end
    in_data = DW'(3);
    repeat (3) begin
      tick();
      n_checks++; if (in_a.ready !== 1'b0 || out_a.data !== DW'(1)) begin n_errors++; $display("FAIL bp_hold got %0h/%0h exp 0/1", in_a.ready, out_a.data); end
    end
    out_ready = 1'b1;
    tick();
    n_checks++; if (out_a.valid !== 1'b1 || out_a.data !== DW'(2)) begin n_errors++; $display("FAIL bp_second got %0h/%0h exp 1/2", out_a.valid, out_a.data); end
    tick();
    n_checks++; if (out_a.valid !== 1'b1 || out_a.data !== DW'(3)) begin n_errors++; $display("FAIL bp_third got %0h/%0h exp 1/3", out_a.valid, out_a.data); end
    in_valid = 1'b0;
    tick();
    n_checks++; if (out_a.valid !== 1'b0) begin n_errors++; $display("FAIL bp_empty got %0h exp 0", out_a.valid); end
    n_checks++; if (stall_a !== 16'd4 || stall_b !== 4'd4) begin n_errors++; $display("FAIL bp_stall got %0d/%0d exp 4/4", stall_a, stall_b); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_data = DW'(11);
    tick();
    in_data = DW'(12);
    tick();
    n_checks++; if (st_a !== ST_FULL || in_a.ready !== 1'b0) begin n_errors++; $display("FAIL flush_full got %0h/%0h exp 3/0", st_a, in_a.ready); end
    flush = 1'b1; in_data = DW'(7); in_ctrl = 8'hA5;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_checks++; if (out_a.valid !== 1'b0 || out_a.ctrl !== 8'h00) begin n_errors++; $display("FAIL flush_out got %0h/%0h exp 0/0", out_a.valid, out_a.ctrl); end
    n_checks++; if (in_a.ready !== 1'b1) begin n_errors++; $display("FAIL flush_ready got %0h exp 1", in_a.ready); end
    out_ready = 1'b1;
    repeat (3) begin
      tick();
      n_checks++; if (out_a.valid !== 1'b0) begin n_errors++; $display("FAIL flush_ghost got %0h data %0h exp 0", out_a.valid, out_a.data); end
    end
    n_checks++; if (stall_a !== 16'd6) begin n_errors++; $display("FAIL flush_stall got %0d exp 6", stall_a); end
  endtask

  task automatic test_saturation();
    out_ready = 1'b0; in_valid = 1'b1; in_data = rand_data();
    tick();
    in_valid = 1'b0;
    repeat (20) tick();
    n_checks++; if (stall_b !== 4'd15) begin n_errors++; $display("FAIL sat_stall got %0d exp 15", stall_b); end
    n_checks++; if (stall_a !== 16'd26) begin n_errors++; $display("FAIL sat_wide_stall got %0d exp 26", stall_a); end
    n_checks++; if (out_a.valid !== 1'b1) begin n_errors++; $display("FAIL sat_valid got %0h exp 1", out_a.valid); end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_no_skid();
    out_ready = 1'b1; in_valid = 1'b0;
    tick(); tick();
    in_valid = 1'b1; in_data = DW'(21); out_ready = 1'b0;
    tick();
    n_checks++; if (out_c.valid !== 1'b1 || out_c.data !== DW'(21)) begin n_errors++; $display("FAIL ns_load got %0h/%0h exp 1/15", out_c.valid, out_c.data); end
    n_checks++; if (in_c.ready !== 1'b0) begin n_errors++; $display("FAIL ns_ready_low got %0h exp 0", in_c.ready); end
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_c.ready !== 1'b1) begin n_errors++; $display("FAIL ns_ready_comb got %0h exp 1", in_c.ready); end
    in_data = DW'(22);
    tick();
    n_checks++; if (out_c.valid !== 1'b1 || out_c.data !== DW'(22)) begin n_errors++; $display("FAIL ns_replace got %0h/%0h exp 1/16", out_c.valid, out_c.data); end
    out_ready = 1'b0; in_data = DW'(23);
    tick(); tick();
    n_checks++; if (out_c.data !== DW'(22) || in_c.ready !== 1'b0) begin n_errors++; $display("FAIL ns_hold got %0h/%0h exp 16/0", out_c.data, in_c.ready); end
    in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick(); tick();
    n_checks++; if (out_c.valid !== 1'b0) begin n_errors++; $display("FAIL ns_drain got %0h exp 0", out_c.valid); end
  endtask

  task automatic test_random();
    logic [EW-1:0] fa, fc;
    for (int n = 0; n < 400; n++) begin
      rst       = ($urandom_range(0, 63) == 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_ctrl   = CW'($urandom());
      in_data   = rand_data();
      tick();
      fa = (exp_qa.size() != 0) ? exp_qa[0] : '0;
      fc = (exp_qc.size() != 0) ? exp_qc[0] : '0;
      n_checks++; if (out_a.valid !== (exp_qa.size() != 0)) begin n_errors++; $display("FAIL rnd_valid_a got %0h exp %0h", out_a.valid, exp_qa.size() != 0); end
      n_checks++; if (out_a.ctrl !== fa[EW-1:DW]) begin n_errors++; $display("FAIL rnd_ctrl_a got %0h exp %0h", out_a.ctrl, fa[EW-1:DW]); end
      if (exp_qa.size() != 0) begin
        n_checks++; if (out_a.data !== fa[DW-1:0]) begin n_errors++; $display("FAIL rnd_data_a got %0h exp %0h", out_a.data, fa[DW-1:0]); end
      end
      n_checks++; if (in_a.ready !== (exp_qa.size() < 2)) begin n_errors++; $display("FAIL rnd_ready_a got %0h exp %0h", in_a.ready, exp_qa.size() < 2); end
      n_checks++; if (stall_a !== 16'(cnt_a)) begin n_errors++; $display("FAIL rnd_stall_a got %0d exp %0d", stall_a, cnt_a); end
      n_checks++; if (out_b.valid !== (exp_qa.size() != 0) || stall_b !== 4'(cnt_b)) begin n_errors++; $display("FAIL rnd_b got %0h/%0d exp %0h/%0d", out_b.valid, stall_b, exp_qa.size() != 0, cnt_b); end
      n_checks++; if (out_c.valid !== (exp_qc.size() != 0) || out_c.ctrl !== fc[EW-1:DW]) begin n_errors++; $display("FAIL rnd_c got %0h/%0h exp %0h/%0h", out_c.valid, out_c.ctrl, exp_qc.size() != 0, fc[EW-1:DW]); end
      if (exp_qc.size() != 0) begin
        n_checks++; if (out_c.data !== fc[DW-1:0]) begin n_errors++; $display("FAIL rnd_data_c got %0h exp %0h", out_c.data, fc[DW-1:0]); end
      end
      n_checks++; if (in_c.ready !== (out_ready || exp_qc.size() == 0)) begin n_errors++; $display("FAIL rnd_ready_c got %0h exp %0h", in_c.ready, out_ready || exp_qc.size() == 0); end
      n_checks++; if (stall_c !== 16'(cnt_c)) begin n_errors++; $display("FAIL rnd_stall_c got %0d exp %0d", stall_c, cnt_c); end
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_saturation();
    test_no_skid();
    test_random();
    // final report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
